// File: rtl/rom_password_top.sv
// Password front-end for the memory-tester game: 4-nibble entry, check against
// an 8-entry store, authentication, RAM-access grant and password change.
module rom_password_top #(
   parameter int unsigned NUM_DIGITS = 4,
   parameter int unsigned NUM_USERS  = 8
) (
   input  logic       clock,
   input  logic       rst,
   input  logic       ROM_access,
   input  logic       rng_button,
   input  logic       auth_button,
   input  logic       log_out,
   input  logic [3:0] toggle_entry,
   input  logic [2:0] internal_id,
   output logic       auth_bit,
   output logic       red_led,
   output logic       green_led,
   output logic       RAM_access,
   output logic       password_change
);

   localparam logic [2:0] IDLE   = 3'd0;
   localparam logic [2:0] ENTRY  = 3'd1;
   localparam logic [2:0] CHECK  = 3'd2;
   localparam logic [2:0] AUTH   = 3'd3;
   localparam logic [2:0] CHANGE = 3'd4;
   localparam logic [2:0] FAIL   = 3'd5;

   localparam logic [1:0] LAST_DIGIT = 2'(NUM_DIGITS - 1);

   logic [2:0]  state;
   logic [1:0]  count;
   logic [15:0] entry;
   logic        auth_prev;
   logic        rng_prev;
   logic [15:0] store [NUM_USERS];

   logic        auth_press;
   logic        rng_press;
   logic [15:0] entry_next;
   logic        store_we;

   function automatic logic [15:0] default_pw(input logic [2:0] id);
      case (id)
         3'd0:    default_pw = 16'h1234;
         3'd1:    default_pw = 16'h5A5A;
         3'd2:    default_pw = 16'hC0DE;
         3'd3:    default_pw = 16'h0F0F;
         3'd4:    default_pw = 16'h47E3;
         3'd5:    default_pw = 16'hBEEF;
         3'd6:    default_pw = 16'h9876;
         default: default_pw = 16'h2468;
      endcase
   endfunction

   assign auth_press = auth_button & ~auth_prev;
   assign rng_press  = rng_button & ~rng_prev;
   assign entry_next = {entry[11:0], toggle_entry};
   assign green_led  = auth_bit;

   // Same gating as the CHANGE branch below: only a live, non-logout 4th press writes.
   assign store_we = ROM_access && !log_out && (state == CHANGE) && auth_press
                     && (count == LAST_DIGIT);

   always_ff @(posedge clock or posedge rst) begin
      if (rst) begin
         auth_prev <= 1'b0;
         rng_prev  <= 1'b0;
      end else begin
         auth_prev <= auth_button;
         rng_prev  <= rng_button;
      end
   end

   always_ff @(posedge clock or posedge rst) begin
      if (rst) begin
         for (int unsigned i = 0; i < NUM_USERS; i++)
            store[i] <= default_pw(3'(i));
      end else if (store_we) begin
         store[internal_id] <= entry_next;
      end
   end

   always_ff @(posedge clock or posedge rst) begin
      if (rst) begin
         state           <= IDLE;
         count           <= '0;
         entry           <= '0;
         auth_bit        <= 1'b0;
         red_led         <= 1'b0;
         RAM_access      <= 1'b0;
         password_change <= 1'b0;
      end else if (!ROM_access) begin
         state           <= IDLE;
         count           <= '0;
         entry           <= '0;
         auth_bit        <= 1'b0;
         red_led         <= 1'b0;
         RAM_access      <= 1'b0;
         password_change <= 1'b0;
      end else if (log_out) begin
         state           <= ENTRY;
         count           <= '0;
         entry           <= '0;
         auth_bit        <= 1'b0;
         red_led         <= 1'b0;
         RAM_access      <= 1'b0;
         password_change <= 1'b0;
      end else begin
         case (state)
            IDLE: state <= ENTRY;
            ENTRY: begin
               if (auth_press) begin
                  entry <= entry_next;
                  if (count == LAST_DIGIT) begin
                     count <= '0;
                     state <= CHECK;
                  end else begin
                     count <= count + 2'd1;
                  end
               end
            end
            CHECK: begin
               if (entry == store[internal_id]) begin
                  state    <= AUTH;
                  auth_bit <= 1'b1;
                  red_led  <= 1'b0;
               end else begin
                  state    <= FAIL;
                  auth_bit <= 1'b0;
                  red_led  <= 1'b1;
               end
            end
            AUTH: begin
               if (rng_press)
                  RAM_access <= 1'b1;
               if (auth_press) begin
                  state           <= CHANGE;
                  count           <= '0;
                  password_change <= 1'b1;
               end
            end
            CHANGE: begin
               if (auth_press) begin
                  entry <= entry_next;
                  if (count == LAST_DIGIT) begin
                     count           <= '0;
                     state           <= AUTH;
                     password_change <= 1'b0;
                  end else begin
                     count <= count + 2'd1;
                  end
               end
            end
            FAIL: begin
               // The clearing press is already the first digit of the next attempt.
               if (auth_press) begin
                  red_led <= 1'b0;
                  entry   <= {12'h000, toggle_entry};
                  count   <= 2'd1;
                  state   <= ENTRY;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_rom_password_top.sv
// Table-driven bench for rom_password_top with a scoreboard of expected output vectors.
module tb_rom_password_top;

   logic       clock        = 1'b0;
   logic       rst          = 1'b0;
   logic       ROM_access   = 1'b1;
   logic       rng_button   = 1'b0;
   logic       auth_button  = 1'b0;
   logic       log_out      = 1'b0;
   logic [3:0] toggle_entry = 4'h0;
   logic [2:0] internal_id  = 3'd0;
   logic       auth_bit;
   logic       red_led;
   logic       green_led;
   logic       RAM_access;
   logic       password_change;

   always #5 clock = ~clock;

   rom_password_top #(.NUM_DIGITS(4), .NUM_USERS(8)) dut (
      .clock           (clock),
      .rst             (rst),
      .ROM_access      (ROM_access),
      .rng_button      (rng_button),
      .auth_button     (auth_button),
      .log_out         (log_out),
      .toggle_entry    (toggle_entry),
      .internal_id     (internal_id),
      .auth_bit        (auth_bit),
      .red_led         (red_led),
      .green_led       (green_led),
      .RAM_access      (RAM_access),
      .password_change (password_change)
   );

   localparam int OP_PRESS  = 0;
   localparam int OP_RNG    = 1;
   localparam int OP_BOTH   = 2;
   localparam int OP_LOGOUT = 3;
   localparam int OP_ROMOFF = 4;
   localparam int OP_RESET  = 5;

   // expected vector bit order: {auth_bit, red_led, green_led, RAM_access, password_change}
   localparam logic [4:0] ZERO   = 5'b00000;
   localparam logic [4:0] AUTHD  = 5'b10100;
   localparam logic [4:0] BAD    = 5'b01000;
   localparam logic [4:0] RAMON  = 5'b10110;
   localparam logic [4:0] CHG    = 5'b10101;
   localparam logic [4:0] CHGRAM = 5'b10111;

   typedef struct {
      int         op;
      logic [3:0] nib;
      logic [2:0] id;
      logic [4:0] exp;
   } vec_t;

   typedef struct {
      string      name;
      logic [4:0] exp;
   } sb_t;

   vec_t tbl[$];
   sb_t  sb[$];
   int   checks = 0;
   int   errors = 0;

   task automatic add(input int op, input logic [3:0] nib, input logic [2:0] id,
                      input logic [4:0] exp);
      vec_t v;
      v.op = op; v.nib = nib; v.id = id; v.exp = exp;
      tbl.push_back(v);
   endtask

   // Four digit presses; outputs stay at mid until the last press settles to fin.
   task automatic add_pw(input logic [15:0] pw, input logic [2:0] id,
                         input logic [4:0] mid, input logic [4:0] fin);
      add(OP_PRESS, pw[15:12], id, mid);
      add(OP_PRESS, pw[11:8],  id, mid);
      add(OP_PRESS, pw[7:4],   id, mid);
      add(OP_PRESS, pw[3:0],   id, fin);
   endtask

   task automatic step;
      @(posedge clock);
      @(negedge clock);
   endtask

   task automatic expect_out(input string name, input logic [4:0] exp);
      sb_t e;
      e.name = name; e.exp = exp;
      sb.push_back(e);
   endtask

   task automatic check_out;
      sb_t        e;
      logic [4:0] got;
      got = {auth_bit, red_led, green_led, RAM_access, password_change};
      checks++;
      if (sb.size() == 0) begin
         errors++;
         $display("FAIL scoreboard_empty got %b", got);
      end else begin
         e = sb.pop_front();
         if (got !== e.exp) begin
            errors++;
            $display("FAIL %s got %b expected %b", e.name, got, e.exp);
         end
      end
   endtask

   task automatic run_op(input vec_t v, input string name);
      internal_id  = v.id;
      toggle_entry = v.nib;
      expect_out(name, v.exp);
      case (v.op)
         OP_PRESS:  begin auth_button = 1'b1; step; auth_button = 1'b0; step; end
         OP_RNG:    begin rng_button = 1'b1; step; rng_button = 1'b0; step; end
         OP_BOTH:   begin auth_button = 1'b1; rng_button = 1'b1; step;
                          auth_button = 1'b0; rng_button = 1'b0; step; end
         OP_LOGOUT: begin log_out = 1'b1; step; log_out = 1'b0; step; end
         OP_ROMOFF: begin ROM_access = 1'b0; step; ROM_access = 1'b1; step; end
         default:   begin rst = 1'b1; step; rst = 1'b0; step; end
      endcase
      check_out();
   endtask

   initial begin
      #100000;
      $display("FAIL timeout");
      $fatal(1, "timeout");
   end

   initial begin
      vec_t v;
      // operation table
      add(OP_RESET, 4'h0, 3'd4, ZERO);
      add_pw(16'h47E3, 3'd4, ZERO, AUTHD);
      add(OP_RNG, 4'h0, 3'd4, RAMON);
      add(OP_LOGOUT, 4'h0, 3'd4, ZERO);
      add_pw(16'h47E3, 3'd4, ZERO, AUTHD);
      add(OP_LOGOUT, 4'h0, 3'd4, ZERO);
      add_pw(16'h47E2, 3'd4, ZERO, BAD);
      add_pw(16'h47E3, 3'd4, ZERO, AUTHD);
      add(OP_PRESS, 4'h9, 3'd4, CHG);
      add(OP_RNG, 4'h0, 3'd4, CHG);
      add_pw(16'h1234, 3'd4, CHG, AUTHD);
      add(OP_LOGOUT, 4'h0, 3'd4, ZERO);
      add_pw(16'h1234, 3'd4, ZERO, AUTHD);
      add(OP_LOGOUT, 4'h0, 3'd4, ZERO);
      add_pw(16'h47E3, 3'd4, ZERO, BAD);
      add(OP_ROMOFF, 4'h0, 3'd4, ZERO);
      add(OP_PRESS, 4'h1, 3'd4, ZERO);
      add(OP_PRESS, 4'h2, 3'd4, ZERO);
      add(OP_ROMOFF, 4'h0, 3'd4, ZERO);
      add_pw(16'h1234, 3'd4, ZERO, AUTHD);
      add(OP_RESET, 4'h0, 3'd4, ZERO);
      add_pw(16'h1234, 3'd4, ZERO, BAD);
      add_pw(16'h47E3, 3'd4, ZERO, AUTHD);
      add(OP_LOGOUT, 4'h0, 3'd4, ZERO);
      add(OP_PRESS, 4'hB, 3'd4, ZERO);
      add(OP_PRESS, 4'hE, 3'd4, ZERO);
      add(OP_PRESS, 4'hE, 3'd5, ZERO);
      add(OP_PRESS, 4'hF, 3'd5, AUTHD);
      add(OP_LOGOUT, 4'h0, 3'd2, ZERO);
      add_pw(16'hC0DE, 3'd2, ZERO, AUTHD);
      add(OP_LOGOUT, 4'h0, 3'd5, ZERO);
      add_pw(16'hBEEF, 3'd5, ZERO, AUTHD);
      add(OP_BOTH, 4'h0, 3'd5, CHGRAM);
      add_pw(16'h0000, 3'd5, CHGRAM, RAMON);

      rst = 1'b1;
      step;
      expect_out("reset_state", ZERO);
      check_out();

      for (int i = 0; i < tbl.size(); i++) begin
         v = tbl[i];
         run_op(v, $sformatf("vec%0d", i));
      end

      // latency: CHECK cycle after the 4th press, result one edge later
      v.op = OP_LOGOUT; v.nib = 4'h0; v.id = 3'd5; v.exp = ZERO;
      run_op(v, "lat_logout");
      for (int i = 0; i < 3; i++) begin
         v.op = OP_PRESS; v.exp = ZERO;
         run_op(v, $sformatf("lat_digit%0d", i));
      end
      auth_button = 1'b1;
      @(posedge clock); #1;
      expect_out("lat_check_cycle", ZERO);
      check_out();
      auth_button = 1'b0;
      @(posedge clock); #1;
      expect_out("lat_result", AUTHD);
      check_out();
      @(negedge clock);

      // a held button is a single digit
      v.op = OP_LOGOUT; v.id = 3'd4; v.exp = ZERO;
      run_op(v, "held_logout");
      internal_id  = 3'd4;
      toggle_entry = 4'h4;
      auth_button  = 1'b1;
      repeat (5) step;
      auth_button = 1'b0;
      step;
      expect_out("held_digit", ZERO);
      check_out();
      v.op = OP_PRESS; v.nib = 4'h7; v.exp = ZERO; run_op(v, "held_d1");
      v.nib = 4'hE; run_op(v, "held_d2");
      v.nib = 4'h3; v.exp = AUTHD; run_op(v, "held_d3");

      // rng held high, then logout while still held
      rng_button = 1'b1;
      repeat (4) step;
      expect_out("rng_held", RAMON);
      check_out();
      log_out = 1'b1;
      step;
      expect_out("rng_logout", ZERO);
      check_out();
      log_out = 1'b0;
      step;
      expect_out("rng_after_logout", ZERO);
      check_out();
      rng_button = 1'b0;
      step;

      if (sb.size() != 0) begin
         errors++;
         $display("FAIL scoreboard_leftover got %0d expected 0", sb.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
